// File: rtl/leds7_cmd_tx_pkg.sv
// Shared 7-segment LED command protocol definitions: header base, digit limit, tx FSM states.
// Used by leds7_cmd_tx and the far-end LED control decoder.
package Leds_7_pkg;

    localparam logic [7:0] LED_HDR_BASE  = 8'hF0;
    localparam logic [3:0] LED_DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_DATA,
        TX_GAP,
        TX_SEEK
    } tx_state_t;

endpackage

// File: rtl/leds7_cmd_tx_if.sv
// Digit request and UART byte handshake bundle for leds7_cmd_tx.
// master = application/UART side, slave = the transmitter.
interface leds7_cmd_tx_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_data;
    logic                    digits_valid;
    logic                    digits_ready;
    logic                    digits_err;
    logic                    done;
    logic [7:0]              uart_data;
    logic                    uart_data_valid;
    logic                    uart_ready;

    modport master (
        output digits_data, digits_valid, uart_ready,
        input  digits_ready, digits_err, done, uart_data, uart_data_valid
    );

    modport slave (
        input  digits_data, digits_valid, uart_ready,
        output digits_ready, digits_err, done, uart_data, uart_data_valid
    );
endinterface

// File: rtl/leds7_cmd_tx.sv
// Serialises a set of BCD digits into header(F0+i)/data byte pairs for the UART TX.
// Define LEDS7_CHANGED_ONLY_EN to send only digits that changed since they were last sent.
module leds7_cmd_tx
    import Leds_7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int GAP_CYCLES = 0
) (
    input logic           clk,
    input logic           reset,
    leds7_cmd_tx_if.slave bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    tx_state_t               state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [GW-1:0]           gap_cnt, gap_cnt_n;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_n;
    logic [7:0]              data_q, data_n;
    logic                    valid_q, valid_n;
    logic                    err_q, err_n;
    logic                    done_q, done_n;
    logic                    bad_nibble;
    logic [3:0]              cur_digit;

`ifdef LEDS7_CHANGED_ONLY_EN
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_n;
    logic [NUM_DIGITS-1:0]   sent_q, sent_n;
    logic [NUM_DIGITS-1:0]   mask_q, mask_n, mask_new;
    logic                    emitted_q, emitted_n;

    always_comb begin
        mask_new = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            mask_new[i] = ~sent_q[i] | (bus.digits_data[4*i +: 4] != shadow_q[4*i +: 4]);
        end
    end
`endif

    always_comb begin
        bad_nibble = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bus.digits_data[4*i +: 4] > LED_DIGIT_MAX) begin
                bad_nibble = 1'b1;
            end
        end
    end

    assign cur_digit = digits_q[4*int'(idx) +: 4];

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        gap_cnt_n = gap_cnt;
        digits_n  = digits_q;
        data_n    = data_q;
        valid_n   = valid_q;
        err_n     = 1'b0;
        done_n    = 1'b0;
`ifdef LEDS7_CHANGED_ONLY_EN
        shadow_n  = shadow_q;
        sent_n    = sent_q;
        mask_n    = mask_q;
        emitted_n = emitted_q;
`endif
        case (state)
            TX_IDLE: begin
                if (bus.digits_valid) begin
                    if (bad_nibble) begin
                        err_n = 1'b1;
                    end else begin
                        digits_n = bus.digits_data;
                        idx_n    = '0;
`ifdef LEDS7_CHANGED_ONLY_EN
                        mask_n    = mask_new;
                        emitted_n = 1'b0;
                        state_n   = TX_SEEK;
`else
                        state_n  = TX_HDR;
                        valid_n  = 1'b1;
                        data_n   = LED_HDR_BASE;
`endif
                    end
                end
            end
            TX_HDR: begin
                if (bus.uart_ready) begin
                    state_n = TX_DATA;
                    data_n  = {4'h0, cur_digit};
                end
            end
            TX_DATA: begin
                if (bus.uart_ready) begin
`ifdef LEDS7_CHANGED_ONLY_EN
                    shadow_n[4*int'(idx) +: 4] = cur_digit;
                    sent_n[idx]                = 1'b1;
                    emitted_n                  = 1'b1;
`endif
                    if (idx == LAST_IDX) begin
                        state_n = TX_IDLE;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
`ifdef LEDS7_CHANGED_ONLY_EN
                        state_n = TX_SEEK;
                        valid_n = 1'b0;
`else
                        if (GAP_CYCLES > 0) begin
                            state_n   = TX_GAP;
                            valid_n   = 1'b0;
                            gap_cnt_n = GW'(GAP_CYCLES);
                        end else begin
                            state_n = TX_HDR;
                            data_n  = LED_HDR_BASE + 8'(idx_n);
                        end
`endif
                    end
                end
            end
            TX_GAP: begin
                // Counter is loaded with GAP_CYCLES, so leaving at 1 gives exactly that many idle cycles.
                if (gap_cnt <= GW'(1)) begin
                    state_n = TX_HDR;
                    valid_n = 1'b1;
                    data_n  = LED_HDR_BASE + 8'(idx);
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
`ifdef LEDS7_CHANGED_ONLY_EN
            TX_SEEK: begin
                // The gap is only inserted when a pair was already emitted in this request.
                if (mask_q[idx]) begin
                    if (GAP_CYCLES > 0 && emitted_q) begin
                        state_n   = TX_GAP;
                        gap_cnt_n = GW'(GAP_CYCLES);
                    end else begin
                        state_n = TX_HDR;
                        valid_n = 1'b1;
                        data_n  = LED_HDR_BASE + 8'(idx);
                    end
                end else if (idx == LAST_IDX) begin
                    state_n = TX_IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
`endif
            default: begin
                state_n = TX_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TX_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            digits_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef LEDS7_CHANGED_ONLY_EN
            shadow_q  <= '0;
            sent_q    <= '0;
            mask_q    <= '0;
            emitted_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            gap_cnt   <= gap_cnt_n;
            digits_q  <= digits_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            err_q     <= err_n;
            done_q    <= done_n;
`ifdef LEDS7_CHANGED_ONLY_EN
            shadow_q  <= shadow_n;
            sent_q    <= sent_n;
            mask_q    <= mask_n;
            emitted_q <= emitted_n;
`endif
        end
    end

    assign bus.digits_ready    = (state == TX_IDLE) & ~reset;
    assign bus.digits_err      = err_q;
    assign bus.done            = done_q;
    assign bus.uart_data       = data_q;
    assign bus.uart_data_valid = valid_q;

endmodule

// File: tb/tb_leds7_cmd_tx.sv
// Directed self-checking bench for leds7_cmd_tx (GAP_CYCLES=0 and GAP_CYCLES=3 instances).
module tb_leds7_cmd_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    leds7_cmd_tx_if #(.NUM_DIGITS(4)) bus0 ();
    leds7_cmd_tx_if #(.NUM_DIGITS(4)) bus3 ();

    leds7_cmd_tx #(.NUM_DIGITS(4), .GAP_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    leds7_cmd_tx #(.NUM_DIGITS(4), .GAP_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus0.digits_valid = 1'b0;
        bus3.digits_valid = 1'b0;
        bus0.uart_ready = 1'b1;
        bus3.uart_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus0.digits_data = 16'h1234;
        bus0.digits_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus0.digits_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", bus0.digits_ready);
        end
        total++;
        if ({bus0.uart_data_valid, bus0.uart_data, bus0.digits_err, bus0.done} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outs got=%b/%h/%b/%b want=0/00/0/0", bus0.uart_data_valid,
                     bus0.uart_data, bus0.digits_err, bus0.done);
        end
        total++;
        if (bus3.uart_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid3 got=%b want=0", bus3.uart_data_valid);
        end
        reset = 1'b0;
        bus0.digits_valid = 1'b0;
        #1;
        total++;
        if (bus0.digits_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", bus0.digits_ready);
        end
    endtask

    task automatic test_err();
        do_reset();
        bus0.digits_data = 16'h3A10;
        bus0.digits_valid = 1'b1;
        @(negedge clk);
        bus0.digits_valid = 1'b0;
        total++;
        if ({bus0.digits_err, bus0.uart_data_valid, bus0.done, bus0.digits_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL err_pulse got err=%b valid=%b done=%b ready=%b want 1/0/0/1",
                     bus0.digits_err, bus0.uart_data_valid, bus0.done, bus0.digits_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({bus0.digits_err, bus0.uart_data_valid, bus0.digits_ready} !== 3'b001) begin
                bad++;
                $display("FAIL err_after c=%0d got err=%b valid=%b ready=%b want 0/0/1", c,
                         bus0.digits_err, bus0.uart_data_valid, bus0.digits_ready);
            end
        end
    endtask

`ifdef LEDS7_CHANGED_ONLY_EN
    task automatic test_changed_only();
        logic [15:0] req [3] = '{16'h5555, 16'h5755, 16'h5755};
        logic [7:0]  exp0 [8] = '{8'hF0, 8'h05, 8'hF1, 8'h05, 8'hF2, 8'h05, 8'hF3, 8'h05};
        logic [7:0]  got [$];
        logic [7:0]  want [$];
        int          done_at;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            got.delete();
            want.delete();
            if (r == 0) begin
                for (int k = 0; k < 8; k++) want.push_back(exp0[k]);
            end else if (r == 1) begin
                want.push_back(8'hF2);
                want.push_back(8'h07);
            end
            bus0.digits_data = req[r];
            bus0.digits_valid = 1'b1;
            @(negedge clk);
            bus0.digits_valid = 1'b0;
            done_at = -1;
            for (int c = 1; c <= 40; c++) begin
                if (bus0.uart_data_valid === 1'b1) got.push_back(bus0.uart_data);
                if (bus0.done === 1'b1) begin
                    done_at = c;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if (done_at < 0) begin
                bad++;
                $display("FAIL chg_done_timeout req=%0d got=none want=done", r);
            end
            total++;
            if (got.size() != want.size()) begin
                bad++;
                $display("FAIL chg_count req=%0d got=%0d want=%0d", r, got.size(), want.size());
            end else begin
                for (int k = 0; k < want.size(); k++) begin
                    total++;
                    if (got[k] !== want[k]) begin
                        bad++;
                        $display("FAIL chg_byte req=%0d k=%0d got=%h want=%h", r, k, got[k], want[k]);
                    end
                end
            end
            if (r == 2) begin
                total++;
                if (done_at != 5) begin
                    bad++;
                    $display("FAIL chg_done_latency got=%0d want=5", done_at);
                end
            end
            @(negedge clk);
        end
    endtask
`else
    task automatic test_basic();
        logic [7:0] exp [8] = '{8'hF0, 8'h00, 8'hF1, 8'h01, 8'hF2, 8'h02, 8'hF3, 8'h03};
        do_reset();
        bus0.digits_data = 16'h3210;
        bus0.digits_valid = 1'b1;
        bus0.uart_ready = 1'b1;
        total++;
        if (bus0.digits_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready got=%b want=1", bus0.digits_ready);
        end
        @(negedge clk);
        bus0.digits_valid = 1'b0;
        bus0.digits_data = 16'h9999;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({bus0.done, bus0.uart_data_valid, bus0.uart_data} !== {2'b01, exp[k]}) begin
                bad++;
                $display("FAIL basic_byte k=%0d got done=%b valid=%b data=%h want 0/1/%h", k,
                         bus0.done, bus0.uart_data_valid, bus0.uart_data, exp[k]);
            end
            @(negedge clk);
        end
        total++;
        if ({bus0.done, bus0.uart_data_valid} !== 2'b10) begin
            bad++;
            $display("FAIL basic_done got done=%b valid=%b want 1/0", bus0.done, bus0.uart_data_valid);
        end
        @(negedge clk);
        total++;
        if ({bus0.done, bus0.digits_ready} !== 2'b01) begin
            bad++;
            $display("FAIL basic_idle got done=%b ready=%b want 0/1", bus0.done, bus0.digits_ready);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [8] = '{8'hF0, 8'h00, 8'hF1, 8'h01, 8'hF2, 8'h02, 8'hF3, 8'h03};
        int         n = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        do_reset();
        bus0.digits_data = 16'h3210;
        bus0.digits_valid = 1'b1;
        bus0.uart_ready = 1'b0;
        @(negedge clk);
        bus0.digits_valid = 1'b0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            bus0.uart_ready = (c % 3 == 2);
            total++;
            if (bus0.uart_data_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_valid c=%0d got=%b want=1", c, bus0.uart_data_valid);
            end
            if (prev_stall) begin
                total++;
                if (bus0.uart_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d got=%h want=%h", c, bus0.uart_data, prev_data);
                end
            end
            if (bus0.uart_data_valid === 1'b1 && bus0.uart_ready) begin
                total++;
                if (bus0.uart_data !== exp[n]) begin
                    bad++;
                    $display("FAIL stall_byte n=%0d got=%h want=%h", n, bus0.uart_data, exp[n]);
                end
                n++;
            end
            prev_stall = bus0.uart_data_valid & ~bus0.uart_ready;
            prev_data = bus0.uart_data;
            @(negedge clk);
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL stall_timeout got=%0d bytes want=8", n);
        end
        total++;
        if (bus0.done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done got=%b want=1", bus0.done);
        end
        bus0.uart_ready = 1'b1;
    endtask

    task automatic test_gap();
        logic       expv;
        logic [7:0] expd;
        do_reset();
        bus3.digits_data = 16'h3210;
        bus3.digits_valid = 1'b1;
        bus3.uart_ready = 1'b1;
        @(negedge clk);
        bus3.digits_valid = 1'b0;
        for (int k = 0; k < 17; k++) begin
            expv = (k % 5) < 2;
            expd = ((k % 5) == 0) ? 8'(8'hF0 + k / 5) : 8'(k / 5);
            total++;
            if (bus3.uart_data_valid !== expv || (expv && bus3.uart_data !== expd)) begin
                bad++;
                $display("FAIL gap_cycle k=%0d got valid=%b data=%h want valid=%b data=%h", k,
                         bus3.uart_data_valid, bus3.uart_data, expv, expd);
            end
            @(negedge clk);
        end
        total++;
        if ({bus3.done, bus3.uart_data_valid} !== 2'b10) begin
            bad++;
            $display("FAIL gap_done got done=%b valid=%b want 1/0", bus3.done, bus3.uart_data_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus0.digits_data = 16'h3210;
        bus0.digits_valid = 1'b1;
        bus0.uart_ready = 1'b1;
        @(negedge clk);
        bus0.digits_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus0.uart_ready = 1'b0;
        total++;
        if ({bus0.uart_data_valid, bus0.uart_data} !== {1'b1, 8'h01}) begin
            bad++;
            $display("FAIL mid_pending got valid=%b data=%h want 1/01", bus0.uart_data_valid, bus0.uart_data);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus0.uart_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_abort got valid=%b want=0", bus0.uart_data_valid);
        end
        reset = 1'b0;
        bus0.uart_ready = 1'b1;
        bus0.digits_data = 16'h4321;
        bus0.digits_valid = 1'b1;
        @(negedge clk);
        bus0.digits_valid = 1'b0;
        total++;
        if ({bus0.uart_data_valid, bus0.uart_data} !== {1'b1, 8'hF0}) begin
            bad++;
            $display("FAIL mid_restart_hdr got valid=%b data=%h want 1/F0", bus0.uart_data_valid, bus0.uart_data);
        end
        @(negedge clk);
        total++;
        if ({bus0.uart_data_valid, bus0.uart_data} !== {1'b1, 8'h01}) begin
            bad++;
            $display("FAIL mid_restart_data got valid=%b data=%h want 1/01", bus0.uart_data_valid, bus0.uart_data);
        end
    endtask
`endif

    initial begin
        bus0.digits_data = '0;
        bus0.digits_valid = 1'b0;
        bus0.uart_ready = 1'b1;
        bus3.digits_data = '0;
        bus3.digits_valid = 1'b0;
        bus3.uart_ready = 1'b1;
        test_reset();
        test_err();
`ifdef LEDS7_CHANGED_ONLY_EN
        test_changed_only();
`else
        test_basic();
        test_stall();
        test_gap();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/leds7_cmd_tx.md
Name: leds7_cmd_tx

Overview:
- Encoder/transmitter for the 7-segment LED command byte protocol: header byte 8'hF0+i selects digit i, next byte carries its value 0..9 in bits [3:0].
- Accepts a parallel set of BCD digits and serialises it as header/data byte pairs into the UART transmit byte stream.
- Sits between application logic (counter/display source) and the UART TX; the LED control decoder on the far end consumes the stream.

Parameters:
- NUM_DIGITS, 4, number of digits sent per request; legal 1..16 (header range F0..FF).
- GAP_CYCLES, 0, idle cycles inserted between consecutive byte pairs; 0 = back-to-back.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- digits_data  input  4*NUM_DIGITS  packed BCD digits, digit i at [4i+3:4i].
- digits_valid  input  1  request valid.
- digits_ready  output  1  block can accept a request.
- digits_err  output  1  one-cycle pulse: request rejected (some nibble > 9).
- done  output  1  one-cycle pulse: last byte of a request accepted by UART.
- uart_data  output  8  byte to UART TX.
- uart_data_valid  output  1  uart_data valid.
- uart_ready  input  1  UART TX accepts byte when uart_data_valid & uart_ready.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: uart_data=0, uart_data_valid=0, digits_err=0, done=0, digit index=0, state=IDLE; digits_ready=0 while reset high.
- digits_ready = (state==IDLE) & ~reset; combinational from state.
- States: IDLE, HDR, DATA, GAP.
- IDLE: on digits_valid & digits_ready, check all nibbles. If any nibble > 9, pulse digits_err next cycle, send no bytes, stay IDLE. Otherwise latch digits, set idx=0, go to HDR.
- Latency: the first header is valid on the cycle after the accept handshake.
- HDR: uart_data=8'hF0+idx, uart_data_valid=1. On uart_ready, go to DATA.
- DATA: uart_data={4'h0,digit[idx]}, uart_data_valid=1. On uart_ready:
  - if idx==NUM_DIGITS-1: pulse done next cycle, return to IDLE, drop valid.
  - otherwise idx++, then GAP if GAP_CYCLES>0, else HDR.
- GAP: uart_data_valid=0 for exactly GAP_CYCLES cycles (down-counter, width clog2(GAP_CYCLES+1)), then HDR.
- Handshake rules:
  - uart_data and uart_data_valid are registered.
  - Once valid is asserted, uart_data stays stable and valid stays high until uart_ready is sampled high.
  - uart_ready held low indefinitely stalls the block with no data loss.
  - Back-to-back bytes with uart_ready=1 every cycle: HDR/DATA advance one byte per cycle.
- digits_data changes after acceptance have no effect; the latched copy is used.
- Any digits_valid while not IDLE is ignored (digits_ready=0).
- Reset mid-request: the sequence aborts at that edge and uart_data_valid drops without handshake; a partial pair is never completed after reset.
- done and digits_err never assert in the same cycle.

Optional Feature:
- LEDS7_CHANGED_ONLY_EN.
- Defined:
  - Keep a shadow register of last-sent digits plus a per-digit sent flag, cleared by reset.
  - At accept, mask[i] = ~sent[i] | (digit[i] != shadow[i]).
  - Add a SEEK state, entered after accept and after each pair/GAP: if mask[idx], go to HDR; else idx++, one cycle per skipped digit.
  - After passing the last digit, pulse done and return to IDLE.
  - An all-zero mask sends no bytes, and done pulses NUM_DIGITS+1 cycles after accept.
  - Shadow entry and sent flag update when that digit's DATA byte is accepted.
  - GAP applies only between emitted pairs.
- Undefined: no shadow or SEEK; every request sends all NUM_DIGITS pairs.

Decomposition:
- Shared package Leds_7_pkg gains:
  - LED_HDR_BASE = 8'hF0
  - LED_DIGIT_MAX = 4'd9
  - a tx state enum typedef
- Both the decoder and this block use these constants.
- No sub-module; the FSM, index and gap counter stay in one module.

Test Plan:
- Digits {3,2,1,0} (d0=0), uart_ready=1, GAP=0 -> bytes F0,00,F1,01,F2,02,F3,03 on 8 consecutive cycles from accept+1; done pulses 1 cycle after last accept.
- Same request, uart_ready toggling 1-of-3 cycles -> identical byte sequence; uart_data stable whenever valid & ~ready.
- digits_data with d2=4'hA -> digits_err pulse at accept+1; no uart_data_valid; digits_ready stays 1.
- GAP_CYCLES=3 -> exactly 3 cycles of uart_data_valid=0 between each DATA accept and the next header.
- Reset asserted while DATA for digit 1 is pending -> uart_data_valid=0 the next cycle; a new request afterwards starts at F0.
- LEDS7_CHANGED_ONLY_EN: send {5,5,5,5}, then {5,7,5,5} -> second request emits only F2,07 then done; a third identical request emits no bytes, and done pulses 5 cycles after accept.
